// File: rtl/conv_pkg.sv
// Shared constants and helpers for the
// convolution datapath.
package conv_pkg;

   localparam int ACT_W = 8;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic int RND(input int s);
      return 1 << (s - 1);
   endfunction

   function automatic int max_act(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   function automatic int min_act(input int w);
      return -(1 << (w - 1));
   endfunction

   localparam int MAX_ACT = max_act(ACT_W);
   localparam int MIN_ACT = min_act(ACT_W);

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO;
// a push at full is taken only alongside a pop.
module sync_fifo_fwft
   import conv_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  push,
   input  logic [W-1:0]          din,
   input  logic                  pop,
   output logic [W-1:0]          dout,
   output logic [clog2(DEPTH):0] count,
   output logic                  full,
   output logic                  empty
);

   localparam int AW = clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [AW:0]   r_cnt;
   logic          w_we;
   logic          w_re;

   assign empty = (r_cnt == '0);
   assign full  = (r_cnt == (AW+1)'(DEPTH));
   assign w_re  = pop && !empty;
   assign w_we  = push && (!full || w_re);
   assign count = r_cnt;

   // Zero when empty so stale memory never shows.
   assign dout = empty ? '0 : r_mem[r_rd];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_we) r_wr <= r_wr + AW'(1);
         if (w_re) r_rd <= r_rd + AW'(1);
         case ({w_we, w_re})
            2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
            2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_we) r_mem[r_wr] <= din;
   end

endmodule

// File: rtl/conv_line_output_buffer.sv
// Realigns the line psum with delayed valid, then
// ReLU, round, saturate and buffer for the next layer.
module conv_line_output_buffer
   import conv_pkg::*;
#(
   parameter int I_PSUM = 16,
   parameter int O_DATA = 8,
   parameter int SHIFT  = 4,
   parameter int LAT    = 5,
   parameter int DEPTH  = 8,
   parameter int RELU   = 1
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_valid,
   input  logic signed [I_PSUM-1:0] i_psum,
   input  logic                     i_ready,
   output logic                     o_valid,
   output logic signed [O_DATA-1:0] o_data,
   output logic [clog2(DEPTH):0]    o_count,
   output logic                     o_full,
   output logic                     o_overflow
);

   localparam int PW = I_PSUM + 1;
   localparam logic signed [PW-1:0] C_RND = PW'(RND(SHIFT));
   localparam logic signed [PW-1:0] C_MAX = PW'(max_act(O_DATA));
   localparam logic signed [PW-1:0] C_MIN = PW'(min_act(O_DATA));

   logic [LAT-1:0]           r_vdly;
   logic                     w_aval;
   logic signed [PW-1:0]     w_v;
   logic signed [PW-1:0]     w_sum;
   logic signed [PW-1:0]     w_r;
   logic signed [O_DATA-1:0] w_sat;
   logic signed [O_DATA-1:0] r_q_data;
   logic                     r_q_vld;
   logic                     r_ovf;
   logic                     w_pop;
   logic                     w_full;
   logic                     w_empty;
   logic [O_DATA-1:0]        w_dout;

   generate
      if (LAT == 1) begin : g_lat1
         always_ff @(posedge i_clk) begin
            if (i_rst) r_vdly <= '0;
            else       r_vdly <= i_valid;
         end
      end else begin : g_latn
         always_ff @(posedge i_clk) begin
            if (i_rst) r_vdly <= '0;
            else       r_vdly <= {r_vdly[LAT-2:0], i_valid};
         end
      end
   endgenerate

   assign w_aval = r_vdly[LAT-1];

   // One guard bit keeps the rounding add exact.
   always_comb begin
      w_v = {i_psum[I_PSUM-1], i_psum};
      if (RELU != 0 && i_psum[I_PSUM-1]) w_v = '0;
      w_sum = w_v + C_RND;
      w_r   = w_sum >>> SHIFT;
      if (w_r > C_MAX)      w_sat = C_MAX[O_DATA-1:0];
      else if (w_r < C_MIN) w_sat = C_MIN[O_DATA-1:0];
      else                  w_sat = w_r[O_DATA-1:0];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_q_vld  <= 1'b0;
         r_q_data <= '0;
      end else begin
         r_q_vld <= w_aval;
         if (w_aval) r_q_data <= w_sat;
      end
   end

   assign o_valid = !w_empty;
   assign w_pop   = o_valid && i_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_ovf <= 1'b0;
      else if (r_q_vld && w_full && !w_pop)
         r_ovf <= 1'b1;
   end

   sync_fifo_fwft #(
      .W     (O_DATA),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .push  (r_q_vld),
      .din   (r_q_data),
      .pop   (w_pop),
      .dout  (w_dout),
      .count (o_count),
      .full  (w_full),
      .empty (w_empty)
   );

   assign o_data     = w_dout;
   assign o_full     = w_full;
   assign o_overflow = r_ovf;

endmodule

// File: tb/tb_conv_line_output_buffer.sv
// Randomised bench for conv_line_output_buffer with
// ReLU and bypass instances against a queue model.
module tb_conv_line_output_buffer;

   localparam int I_PSUM = 16;
   localparam int O_DATA = 8;
   localparam int SHIFT  = 4;
   localparam int LAT    = 5;
   localparam int DEPTH  = 8;
   localparam int CW     = $clog2(DEPTH) + 1;

   logic          clk  = 1'b0;
   logic          rst  = 1'b0;
   logic          vld  = 1'b0;
   logic          rdy  = 1'b0;
   logic [15:0]   psum = '0;

   logic          ov1, ov0, fu1, fu0, of1, of0;
   logic [7:0]    d1, d0;
   logic [CW-1:0] c1, c0;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] mq1[$];
   logic [7:0] mq0[$];
   bit         vq[$];
   bit         pv;
   bit         ovf1, ovf0;
   logic [7:0] pd1, pd0;

   always #5 clk = ~clk;

   conv_line_output_buffer #(
      .I_PSUM(I_PSUM), .O_DATA(O_DATA), .SHIFT(SHIFT),
      .LAT(LAT), .DEPTH(DEPTH), .RELU(1)
   ) u_dut_relu (
      .i_clk(clk), .i_rst(rst), .i_valid(vld),
      .i_psum(psum), .i_ready(rdy),
      .o_valid(ov1), .o_data(d1), .o_count(c1),
      .o_full(fu1), .o_overflow(of1)
   );

   conv_line_output_buffer #(
      .I_PSUM(I_PSUM), .O_DATA(O_DATA), .SHIFT(SHIFT),
      .LAT(LAT), .DEPTH(DEPTH), .RELU(0)
   ) u_dut_lin (
      .i_clk(clk), .i_rst(rst), .i_valid(vld),
      .i_psum(psum), .i_ready(rdy),
      .o_valid(ov0), .o_data(d0), .o_count(c0),
      .o_full(fu0), .o_overflow(of0)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)",
                  tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] quant(input int p, input bit relu);
      int v;
      int r;
      v = (relu && p < 0) ? 0 : p;
      r = (v + (1 << (SHIFT - 1))) >>> SHIFT;
      if (r > 127)  r = 127;
      if (r < -128) r = -128;
      return 8'(r);
   endfunction

   function automatic logic [15:0] rnd16();
      int sel;
      sel = $urandom_range(0, 3);
      case (sel)
         0:       return 16'($urandom_range(0, 600) - 300);
         1:       return ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic model_edge();
      bit al;
      if (rst) begin
         vq.delete();
         for (int i = 0; i < LAT; i++) vq.push_back(1'b0);
         pv = 1'b0;
         mq1.delete();
         mq0.delete();
         ovf1 = 1'b0;
         ovf0 = 1'b0;
      end else begin
         al = vq.pop_front();
         vq.push_back(vld);
         if (mq1.size() != 0 && rdy) void'(mq1.pop_front());
         if (mq0.size() != 0 && rdy) void'(mq0.pop_front());
         if (pv) begin
            if (mq1.size() < DEPTH) mq1.push_back(pd1);
            else ovf1 = 1'b1;
            if (mq0.size() < DEPTH) mq0.push_back(pd0);
            else ovf0 = 1'b1;
         end
         pv = al;
         if (al) begin
            pd1 = quant(int'($signed(psum)), 1'b1);
            pd0 = quant(int'($signed(psum)), 1'b0);
         end
      end
   endtask

   task automatic check_all();
      chk("valid_relu", int'(ov1), int'(mq1.size() != 0));
      chk("data_relu", int'(d1),
          (mq1.size() != 0) ? int'(mq1[0]) : 0);
      chk("count_relu", int'(c1), mq1.size());
      chk("full_relu", int'(fu1), int'(mq1.size() == DEPTH));
      chk("ovf_relu", int'(of1), int'(ovf1));
      chk("valid_lin", int'(ov0), int'(mq0.size() != 0));
      chk("data_lin", int'(d0),
          (mq0.size() != 0) ? int'(mq0[0]) : 0);
      chk("count_lin", int'(c0), mq0.size());
      chk("full_lin", int'(fu0), int'(mq0.size() == DEPTH));
      chk("ovf_lin", int'(of0), int'(ovf0));
   endtask

   task automatic cyc(input bit v, input logic [15:0] p,
                      input bit r, input bit rs);
      vld  = v;
      psum = p;
      rdy  = r;
      rst  = rs;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic send(input int vals[$], input bit r, input int tail);
      int n;
      n = vals.size();
      for (int c = 0; c < n + LAT + tail; c++) begin
         logic [15:0] p;
         p = (c >= LAT && c - LAT < n) ? 16'(vals[c - LAT]) : rnd16();
         cyc(c < n, p, r, 1'b0);
      end
   endtask

   initial begin
      int q[$];
      logic [7:0] e1 [6];
      logic [7:0] e0 [6];
      e1 = '{8'd2, 8'd1, 8'd0, 8'd127, 8'd127, 8'd0};
      e0 = '{8'd2, 8'd1, 8'hFD, 8'd127, 8'd127, 8'h80};

      for (int i = 0; i < 3; i++) cyc(1'b1, rnd16(), 1'b1, 1'b1);
      chk("rst_count", int'(c1), 0);
      chk("rst_valid", int'(ov1), 0);
      chk("rst_data", int'(d1), 0);
      for (int i = 0; i < 10; i++) cyc(1'b0, rnd16(), 1'b1, 1'b0);

      cyc(1'b1, rnd16(), 1'b0, 1'b0);
      for (int c = 1; c <= 6; c++) begin
         cyc(1'b0, (c == 5) ? 16'd100 : rnd16(), 1'b0, 1'b0);
         if (c == 5) chk("align_early", int'(ov1), 0);
      end
      chk("align_valid", int'(ov1), 1);
      chk("align_data", int'(d1), 6);
      chk("align_count", int'(c1), 1);
      for (int i = 0; i < 8; i++) cyc(1'b0, rnd16(), 1'b1, 1'b0);
      chk("align_drained", int'(c1), 0);

      q = '{24, 23, -50, 5000, 32767, -32768};
      send(q, 1'b0, 2);
      chk("round_count", int'(c1), 6);
      for (int i = 0; i < 6; i++) begin
         chk("round_relu", int'(d1), int'(e1[i]));
         chk("round_lin", int'(d0), int'(e0[i]));
         cyc(1'b0, rnd16(), 1'b1, 1'b0);
      end
      chk("round_empty", int'(ov1), 0);

      q = '{16, 32, 48, 64, 80, 96, 112, 128};
      send(q, 1'b0, 2);
      chk("bp_count", int'(c1), 8);
      chk("bp_full", int'(fu1), 1);
      for (int i = 1; i <= 8; i++) begin
         chk("bp_order", int'(d1), i);
         cyc(1'b0, rnd16(), 1'b1, 1'b0);
      end
      chk("bp_drained", int'(c1), 0);

      send(q, 1'b0, 2);
      q = '{144};
      send(q, 1'b0, 2);
      chk("ovf_flag", int'(of1), 1);
      chk("ovf_count", int'(c1), 8);
      chk("ovf_head", int'(d1), 1);
      for (int c = 0; c < LAT + 3; c++)
         cyc(c == 0, (c == LAT) ? 16'd160 : rnd16(),
             c == LAT + 1, 1'b0);
      chk("pushpop_count", int'(c1), 8);
      chk("pushpop_head", int'(d1), 2);
      for (int i = 0; i < 10; i++) cyc(1'b0, rnd16(), 1'b1, 1'b0);

      for (int i = 0; i < 1500; i++)
         cyc($urandom_range(0, 9) < 6, rnd16(),
             $urandom_range(0, 9) < ((i < 750) ? 3 : 8), 1'b0);

      for (int i = 0; i < 12; i++) cyc(1'b0, rnd16(), 1'b1, 1'b0);
      q = '{40, -40, 300, -3000, 7};
      send(q, 1'b0, 2);
      chk("mid_count", int'(c1), 5);
      for (int i = 0; i < 3; i++) cyc(1'b1, rnd16(), 1'b0, 1'b0);
      cyc(1'b0, rnd16(), 1'b0, 1'b1);
      chk("mid_rst_count", int'(c1), 0);
      chk("mid_rst_valid", int'(ov1), 0);
      chk("mid_rst_ovf", int'(of1), 0);
      for (int i = 0; i < 20; i++)
         cyc(1'b0, rnd16(), $urandom_range(0, 1) != 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
